// File: rtl/mod_exp_controller_if.sv
`default_nettype none
// ============================================================================
//  Module      : mod_exp_controller_if
//  Description : Operand / enable / write-strobe bus between the modular
//                exponentiation controller (master) and the multi-cycle
//                modulo unit (slave).
//  Signals     : mod_a      dividend to the modulo unit
//                mod_b      divisor to the modulo unit
//                mod_ena    one-cycle request pulse
//                mod_result remainder returned by the modulo unit
//                mod_done   one-cycle write strobe qualifying mod_result
//  Revision    : 1.0 - initial release
// ============================================================================
interface mod_exp_controller_if #(
    parameter int WIDTH = 32
) ();
    logic [WIDTH-1:0] mod_a;
    logic [WIDTH-1:0] mod_b;
    logic             mod_ena;
    logic [WIDTH-1:0] mod_result;
    logic             mod_done;

    modport master (
        output mod_a,
        output mod_b,
        output mod_ena,
        input  mod_result,
        input  mod_done
    );

    modport slave (
        input  mod_a,
        input  mod_b,
        input  mod_ena,
        output mod_result,
        output mod_done
    );
endinterface
`default_nettype wire

// File: rtl/mod_exp_controller.sv
`default_nettype none
// ============================================================================
//  Module      : mod_exp_controller
//  Description : Computes result = base^exp mod n with right-to-left
//                square-and-multiply. Every reduction is delegated to the
//                external multi-cycle modulo unit over mod_bus.
//  Ports       : clock, reset      rising-edge clock, async active-high reset
//                start             one-cycle request, sampled when idle
//                base, exp, n      operands, captured on accepted start
//                busy              high while an operation is in flight
//                done              one-cycle pulse, result/error valid
//                result, error     outcome, held until the next start
//                mod_bus (master)  mod_a / mod_b / mod_ena / mod_result /
//                                  mod_done to the modulo unit
//  Revision    : 1.0 - initial release
// ============================================================================
module mod_exp_controller #(
    parameter int WIDTH   = 32,
    parameter int TIMEOUT = 256
) (
    input  wire              clock,
    input  wire              reset,
    input  wire              start,
    input  wire [WIDTH-1:0]  base,
    input  wire [WIDTH-1:0]  exp,
    input  wire [WIDTH-1:0]  n,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] result,
    output logic             error,
    mod_exp_controller_if.master mod_bus
);

    localparam int c_CNT_W = $clog2(TIMEOUT + 1);
    // The timeout decision is taken in the last WAIT cycle so that FINISH
    // (and therefore done) lands exactly TIMEOUT cycles after mod_ena.
    localparam logic [c_CNT_W-1:0] c_CNT_LAST = c_CNT_W'(TIMEOUT - 2);

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_CHECK  = 3'd1,
        ST_REQ    = 3'd2,
        ST_WAIT   = 3'd3,
        ST_LOOP   = 3'd4,
        ST_FINISH = 3'd5
    } state_t;

    // Destination of the reduction currently in flight.
    typedef enum logic [1:0] {
        OP_REDUCE = 2'd0,
        OP_MUL    = 2'd1,
        OP_SQR    = 2'd2
    } op_t;

    state_t              r_state, w_state_next;
    op_t                 r_op, w_op_next;
    logic [WIDTH-1:0]    r_r, w_r_next;          // accumulator
    logic [WIDTH-1:0]    r_b, w_b_next;          // running base
    logic [WIDTH-1:0]    r_e, w_e_next;          // remaining exponent
    logic [WIDTH-1:0]    r_n, w_n_next;          // captured modulus
    logic [WIDTH-1:0]    r_mod_a, w_mod_a_next;
    logic [WIDTH-1:0]    r_result, w_result_next;
    logic                r_error, w_error_next;
    logic [c_CNT_W-1:0]  r_cnt, w_cnt_next;

    logic [WIDTH-1:0]    w_e_shift;
    logic [WIDTH-1:0]    w_prod_rb;
    logic [WIDTH-1:0]    w_prod_bb;

    // Operands are below n < 2^(WIDTH/2), so the truncated product is exact.
    assign w_e_shift = r_e >> 1;
    assign w_prod_rb = r_r * r_b;
    assign w_prod_bb = r_b * r_b;

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            r_state  <= ST_IDLE;
            r_op     <= OP_REDUCE;
            r_r      <= '0;
            r_b      <= '0;
            r_e      <= '0;
            r_n      <= '0;
            r_mod_a  <= '0;
            r_result <= '0;
            r_error  <= 1'b0;
            r_cnt    <= '0;
        end else begin
            r_state  <= w_state_next;
            r_op     <= w_op_next;
            r_r      <= w_r_next;
            r_b      <= w_b_next;
            r_e      <= w_e_next;
            r_n      <= w_n_next;
            r_mod_a  <= w_mod_a_next;
            r_result <= w_result_next;
            r_error  <= w_error_next;
            r_cnt    <= w_cnt_next;
        end
    end

    always_comb begin
        w_state_next  = r_state;
        w_op_next     = r_op;
        w_r_next      = r_r;
        w_b_next      = r_b;
        w_e_next      = r_e;
        w_n_next      = r_n;
        w_mod_a_next  = r_mod_a;
        w_result_next = r_result;
        w_error_next  = r_error;
        w_cnt_next    = r_cnt;

        case (r_state)
            ST_IDLE: begin
                if (start) begin
                    w_b_next      = base;
                    w_e_next      = exp;
                    w_n_next      = n;
                    w_result_next = '0;
                    w_error_next  = 1'b0;
                    w_state_next  = ST_CHECK;
                end
            end

            ST_CHECK: begin
                if (r_n == '0) begin
                    w_error_next  = 1'b1;
                    w_result_next = '0;
                    w_state_next  = ST_FINISH;
                end else if (r_n == WIDTH'(1)) begin
                    w_result_next = '0;
                    w_state_next  = ST_FINISH;
                end else begin
                    w_r_next     = WIDTH'(1);
                    w_mod_a_next = r_b;
                    w_op_next    = OP_REDUCE;
                    w_state_next = ST_REQ;
                end
            end

            ST_REQ: begin
                w_cnt_next   = '0;
                w_state_next = ST_WAIT;
            end

            ST_WAIT: begin
                if (mod_bus.mod_done) begin
                    if (r_op == OP_MUL) begin
                        w_r_next = mod_bus.mod_result;
                    end else begin
                        w_b_next = mod_bus.mod_result;
                    end
                    w_state_next = ST_LOOP;
                end else if (r_cnt == c_CNT_LAST) begin
                    w_error_next  = 1'b1;
                    w_result_next = '0;
                    w_state_next  = ST_FINISH;
                end else begin
                    w_cnt_next = r_cnt + 1'b1;
                end
            end

            ST_LOOP: begin
                if ((r_op != OP_MUL) && (r_e == '0)) begin
                    w_result_next = r_r;
                    w_state_next  = ST_FINISH;
                end else if ((r_op != OP_MUL) && r_e[0]) begin
                    w_mod_a_next = w_prod_rb;
                    w_op_next    = OP_MUL;
                    w_state_next = ST_REQ;
                end else begin
                    // Consume the current exponent bit, then square only if
                    // bits remain; the final squaring would be discarded.
                    w_e_next = w_e_shift;
                    if (w_e_shift != '0) begin
                        w_mod_a_next = w_prod_bb;
                        w_op_next    = OP_SQR;
                        w_state_next = ST_REQ;
                    end else begin
                        w_result_next = r_r;
                        w_state_next  = ST_FINISH;
                    end
                end
            end

            ST_FINISH: begin
                w_state_next = ST_IDLE;
            end

            default: begin
                w_state_next = ST_IDLE;
            end
        endcase
    end

    assign busy            = (r_state != ST_IDLE) && (r_state != ST_FINISH);
    assign done            = (r_state == ST_FINISH);
    assign result          = r_result;
    assign error           = r_error;
    assign mod_bus.mod_a   = r_mod_a;
    assign mod_bus.mod_b   = r_n;
    assign mod_bus.mod_ena = (r_state == ST_REQ);

endmodule
`default_nettype wire
